// File: rtl/adc_scan_scheduler.sv
// Conversion scheduler for the 12-bit SPI ADC master: periodic scan of a channel mask plus priority manual requests.
// Latency: request handshake or scan tick -> spi_start 1 cycle; spi_done -> res_valid/latest 1 cycle.
// Backpressure: req_ready is high only in IDLE; scan ticks arriving while a scan is pending are dropped and flag overrun.
//
// Ports: clk/rst_n (async active-low); enable/period/ch_mask configure the scan timer;
// req_valid/req_ready/req_ch is the manual request handshake; spi_start/spi_chan/spi_done/spi_data
// drive the SPI master; res_valid/res_ch/res_data/res_manual announce each result; latest holds the
// last result per channel; scan_busy/overrun/timeout_err are status, clr_flags clears the sticky flags.
// Optional feature macro: ADC_SCAN_TIMEOUT_EN builds the spi_done watchdog (TIMEOUT cycles).
module adc_scan_scheduler #(
    parameter int NUM_CH  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [15:0]            period,
    input  logic [NUM_CH-1:0]      ch_mask,
    input  logic                   req_valid,
    input  logic [$clog2(NUM_CH)-1:0] req_ch,
    output logic                   req_ready,
    output logic                   spi_start,
    output logic [$clog2(NUM_CH)-1:0] spi_chan,
    input  logic                   spi_done,
    input  logic [11:0]            spi_data,
    output logic                   res_valid,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic [11:0]            res_data,
    output logic                   res_manual,
    output logic [NUM_CH*12-1:0]   latest,
    output logic                   scan_busy,
    output logic                   overrun,
    input  logic                   clr_flags,
    output logic                   timeout_err
);
    localparam int CH_W = $clog2(NUM_CH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    logic [1:0]        state;
    logic              run_q;       // low until the first edge after reset release
    logic [15:0]       tmr;
    logic [NUM_CH-1:0] pend;
    logic [CH_W-1:0]   cur_ch;
    logic              cur_manual;

    logic              counting;
    logic              tick;
    logic              snap;
    logic              req_acc;
    logic              scan_sel;
    logic              scan_end;
    logic              wd_fire;
    logic [NUM_CH-1:0] pend_eff;
    logic [NUM_CH-1:0] pend_nxt;
    logic [CH_W-1:0]   low_ch;

    assign counting  = run_q && enable && (period != 16'd0);
    assign tick      = counting && (tmr <= 16'd1);
    assign snap      = tick && !scan_busy;
    // A tick taken in IDLE is arbitrated in the same cycle so the scan starts one cycle later.
    assign pend_eff  = snap ? ch_mask : pend;
    assign req_ready = run_q && (state == S_IDLE);
    assign req_acc   = req_valid && req_ready;
    assign scan_sel  = run_q && (state == S_IDLE) && !req_acc && (pend_eff != '0);
    // The last scan channel has already been cleared from pend when it was issued.
    assign scan_end  = scan_busy && !cur_manual && (pend == '0) &&
                       ((state == S_STORE) || wd_fire);

    assign spi_start = (state == S_ISSUE);
    assign spi_chan  = cur_ch;

    always_comb begin
        low_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_eff[i]) begin
                low_ch = CH_W'(i);
            end
        end
    end

    always_comb begin
        pend_nxt = pend_eff;
        if (scan_sel) begin
            pend_nxt[low_ch] = 1'b0;
        end
        if (!enable) begin
            pend_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            tmr   <= '0;
        end else begin
            run_q <= 1'b1;
            if (!counting || tick) begin
                tmr <= period;
            end else begin
                tmr <= tmr - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            scan_busy <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (!enable || scan_end) begin
                scan_busy <= 1'b0;
            end else if (snap && (ch_mask != '0)) begin
                scan_busy <= 1'b1;
            end
            if (tick && scan_busy) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur_ch     <= '0;
            cur_manual <= 1'b0;
            res_valid  <= 1'b0;
            res_ch     <= '0;
            res_data   <= '0;
            res_manual <= 1'b0;
            latest     <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_acc) begin
                        cur_ch     <= req_ch;
                        cur_manual <= 1'b1;
                        state      <= S_ISSUE;
                    end else if (scan_sel) begin
                        cur_ch     <= low_ch;
                        cur_manual <= 1'b0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_BUSY;
                S_BUSY: begin
                    if (spi_done) begin
                        res_valid              <= 1'b1;
                        res_ch                 <= cur_ch;
                        res_data               <= spi_data;
                        res_manual             <= cur_manual;
                        latest[12*cur_ch +: 12] <= spi_data;
                        state                  <= S_STORE;
                    end else if (wd_fire) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ADC_SCAN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    // Counts cycles since spi_start: holds k in the k-th cycle after the ISSUE cycle.
    logic [WD_W-1:0] wd_cnt;
    logic            to_err_q;

    assign wd_fire     = (state == S_BUSY) && !spi_done && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign timeout_err = to_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                wd_cnt <= WD_W'(1);
            end else if (state == S_BUSY) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_fire) begin
                to_err_q <= 1'b1;
            end else if (clr_flags) begin
                to_err_q <= 1'b0;
            end
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign wd_fire        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Self-checking bench for adc_scan_scheduler: SPI master model plus result scoreboard.
// Latency: timing checks are cycle-exact relative to enable, spi_start and the request handshake.
// Backpressure: manual requests are held until req_ready is observed.
module tb_adc_scan_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] period;
    logic [7:0]  ch_mask;
    logic        req_valid;
    logic [2:0]  req_ch;
    logic        req_ready;
    logic        spi_start;
    logic [2:0]  spi_chan;
    logic        spi_done;
    logic [11:0] spi_data;
    logic        res_valid;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    logic        res_manual;
    logic [95:0] latest;
    logic        scan_busy;
    logic        overrun;
    logic        clr_flags;
    logic        timeout_err;

    adc_scan_scheduler #(.NUM_CH(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .ch_mask(ch_mask),
        .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
        .spi_start(spi_start), .spi_chan(spi_chan), .spi_done(spi_done), .spi_data(spi_data),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data), .res_manual(res_manual),
        .latest(latest), .scan_busy(scan_busy), .overrun(overrun),
        .clr_flags(clr_flags), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ch;
        logic       man;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] data_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          spi_dly = 30;
    bit          spi_hang = 1'b0;
    int          spi_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SPI master model: done pulse spi_dly cycles after spi_start, random data.
    initial begin
        spi_done = 1'b0;
        spi_data = '0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (!rst_n) begin
                spi_cnt = 0;
            end else if (spi_cnt > 0) begin
                spi_cnt--;
                if (spi_cnt == 0) begin
                    spi_data = 12'($urandom_range(0, 4095));
                    spi_done = 1'b1;
                    data_q.push_back(spi_data);
                end
            end else if (spi_start && !spi_hang) begin
                spi_cnt = spi_dly;
            end
        end
    end

    // Result monitor / scoreboard.
    initial begin
        forever begin
            exp_t        e;
            logic [11:0] d;
            @(negedge clk);
            if (rst_n && res_valid) begin
                check("res_expected", exp_q.size() != 0, 1);
                check("data_expected", data_q.size() != 0, 1);
                if (exp_q.size() != 0 && data_q.size() != 0) begin
                    e = exp_q.pop_front();
                    d = data_q.pop_front();
                    check("res_ch", res_ch, e.ch);
                    check("res_manual", res_manual, e.man);
                    check("res_data", res_data, d);
                    check("latest", latest[12*e.ch +: 12], d);
                end
            end
        end
    end

    task automatic wait_start(input int budget, output int t);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (spi_start) begin
                ok = 1'b1;
                break;
            end
        end
        t = cyc;
        check("start_in_time", ok, 1);
    endtask

    task automatic wait_res_n(input int n, input int budget, input bit drop_en);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(negedge clk);
            if (res_valid) begin
                seen++;
                if (seen == n && drop_en) enable = 1'b0;
            end
        end
        check("res_in_time", seen, n);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_in_time", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic count_starts(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (spi_start) c++;
        end
    endtask

    task automatic setup(input logic [15:0] p, input logic [7:0] m);
        enable  = 1'b0;
        period  = p;
        ch_mask = m;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t_en, t0, t1, c;
        bit ok;
        rst_n = 1'b0; enable = 1'b0; period = '0; ch_mask = '0;
        req_valid = 1'b0; req_ch = '0; clr_flags = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_spi_start", spi_start, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_latest", latest != '0, 0);
        check("rst_flags", {scan_busy, overrun, timeout_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_req_ready", req_ready, 1);

        // Periodic scan of ch0 and ch2
        setup(16'd100, 8'b0000_0101);
        spi_dly = 30;
        exp_q.push_back('{ch: 3'd0, man: 1'b0});
        exp_q.push_back('{ch: 3'd2, man: 1'b0});
        enable = 1'b1;
        t_en = cyc;
        wait_start(150, t0);
        check("first_tick_lat", t0 - t_en, 100);
        check("first_chan", spi_chan, 0);
        wait_res_n(2, 150, 1'b0);
        check("busy_at_last_store", scan_busy, 1);
        @(negedge clk);
        check("busy_after_scan", scan_busy, 0);
        exp_q.push_back('{ch: 3'd0, man: 1'b0});
        exp_q.push_back('{ch: 3'd2, man: 1'b0});
        wait_start(100, t1);
        check("scan_period", t1 - t0, 100);
        wait_drain(150);

        // Manual request raised while ch0 is converting
        spi_dly = 20;
        exp_q.push_back('{ch: 3'd0, man: 1'b0});
        exp_q.push_back('{ch: 3'd5, man: 1'b1});
        exp_q.push_back('{ch: 3'd2, man: 1'b0});
        wait_start(100, t1);
        req_valid = 1'b1;
        req_ch    = 3'd5;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("req_accepted", ok, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("req_lat_start", spi_start, 1);
        check("req_lat_chan", spi_chan, 5);
        wait_drain(200);

        // enable falls mid-scan: current result completes, rest abandoned
        exp_q.push_back('{ch: 3'd0, man: 1'b0});
        wait_start(150, t1);
        @(negedge clk);
        enable = 1'b0;
        wait_drain(100);
        check("busy_after_disable", scan_busy, 0);
        count_starts(150, c);
        check("no_start_disabled", c, 0);

        // Empty mask
        setup(16'd10, 8'h00);
        enable = 1'b1;
        count_starts(100, c);
        check("no_start_empty_mask", c, 0);
        check("busy_empty_mask", scan_busy, 0);
        check("no_overrun_yet", overrun, 0);

        // period = 0 halts the timer
        setup(16'd0, 8'b0000_0101);
        enable = 1'b1;
        count_starts(200, c);
        check("no_start_period0", c, 0);

        // Overrun: tick every 10 cycles, conversions take 40
        setup(16'd10, 8'b0000_0101);
        spi_dly = 40;
        exp_q.push_back('{ch: 3'd0, man: 1'b0});
        exp_q.push_back('{ch: 3'd2, man: 1'b0});
        enable = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            clr_flags = (k == 24) || (k == 29);
            if (k == 9)  check("ovr_before_2nd_tick", overrun, 0);
            if (k == 10) check("tick10_start", spi_start, 1);
            if (k == 20) check("ovr_set", overrun, 1);
            if (k == 25) check("ovr_cleared", overrun, 0);
            if (k == 30) check("ovr_set_beats_clr", overrun, 1);
        end
        wait_res_n(2, 200, 1'b1);
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("ovr_final_clr", overrun, 0);
        check("timeout_err_idle", timeout_err, 0);

`ifdef ADC_SCAN_TIMEOUT_EN
        // Watchdog: SPI never answers
        setup(16'd400, 8'b0000_0101);
        spi_hang = 1'b1;
        enable = 1'b1;
        wait_start(500, t1);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 63) check("to_not_yet", timeout_err, 0);
            if (k == 64) check("to_set", timeout_err, 1);
        end
        wait_start(10, t1);
        check("to_next_chan", spi_chan, 2);
        enable = 1'b0;
        repeat (70) @(negedge clk);
        spi_hang = 1'b0;
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("to_cleared", timeout_err, 0);
`endif

        // Async reset while BUSY
        setup(16'd20, 8'b0000_0101);
        spi_dly = 30;
        enable = 1'b1;
        wait_start(100, t1);
        repeat (5) @(negedge clk);
        clr_flags = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_spi_start", spi_start, 0);
        check("arst_spi_chan", spi_chan, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_res", {res_valid, res_manual, res_ch, res_data}, 0);
        check("arst_latest", latest != '0, 0);
        check("arst_flags", {scan_busy, overrun, timeout_err}, 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_rel_ready", req_ready, 1);
        count_starts(60, c);
        check("arst_no_start", c, 0);
        check("exp_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
